// File: rtl/block_nest_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : block_chk_pkg
// Description : Shared matcher states, ASCII constants and character helpers
//               for the BEGIN/END nesting checker.
// Revision    : 1.0 - initial release
// ============================================================================
package block_chk_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_B     = 4'd1,
        S_BE    = 4'd2,
        S_BEG   = 4'd3,
        S_BEGI  = 4'd4,
        S_BEGIN = 4'd5,
        S_E     = 4'd6,
        S_EN    = 4'd7,
        S_END   = 4'd8,
        S_OTHER = 4'd9
    } kw_state_t;

    localparam logic [7:0] c_space    = 8'h20;
    localparam logic [7:0] c_tab      = 8'h09;
    localparam logic [7:0] c_lf       = 8'h0A;
    localparam logic [7:0] c_cr       = 8'h0D;
    localparam logic [7:0] c_comma    = 8'h2C;
    localparam logic [7:0] c_semi     = 8'h3B;
    localparam logic [7:0] c_case_bit = 8'h20;

    function automatic logic is_delim(input logic [7:0] ch, input logic punct);
        logic r;
        r = (ch == c_space);
        if (punct) begin
            r = r || (ch == c_tab) || (ch == c_lf) || (ch == c_cr)
                  || (ch == c_comma) || (ch == c_semi);
        end
        return r;
    endfunction

    function automatic logic [7:0] fold_lower(input logic [7:0] ch);
        return ((ch >= 8'h41) && (ch <= 8'h5A)) ? (ch | c_case_bit) : ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_nest_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : block_nest_checker_if
// Description : Character stream in, nesting status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface block_nest_checker_if #(
    parameter int DEPTH_W = 8
);
    logic               in_valid;
    logic [7:0]         in;
    logic [DEPTH_W-1:0] depth;
    logic               balanced;
    logic               err_underflow;
    logic               err_overflow;

    modport master (
        output in_valid, in,
        input  depth, balanced, err_underflow, err_overflow
    );

    modport slave (
        input  in_valid, in,
        output depth, balanced, err_underflow, err_overflow
    );
endinterface
`default_nettype wire

// File: rtl/block_nest_checker_kw_matcher.sv
`default_nettype none
// ============================================================================
// Module      : kw_matcher
// Description : Word-level recogniser for the keywords "begin" and "end".
// Revision    : 1.0 - initial release
// ============================================================================
module kw_matcher
    import block_chk_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_in_valid,
    input  wire logic [7:0] i_ch,
    input  wire logic       i_delim,
    output logic            o_at_begin,
    output logic            o_at_end,
    output logic            o_commit_begin,
    output logic            o_commit_end,
    output logic            o_next_begin,
    output logic            o_next_end
);

    kw_state_t r_state;
    kw_state_t w_next;

    always_comb begin
        w_next         = r_state;
        o_commit_begin = 1'b0;
        o_commit_end   = 1'b0;
        if (i_in_valid) begin
            if (i_delim) begin
                o_commit_begin = (r_state == S_BEGIN);
                o_commit_end   = (r_state == S_END);
                w_next         = S_IDLE;
            end else begin
                // Any letter that breaks a keyword prefix drops to OTHER until the next delimiter
                case (r_state)
                    S_IDLE:  w_next = (i_ch == "b") ? S_B :
                                      (i_ch == "e") ? S_E : S_OTHER;
                    S_B:     w_next = (i_ch == "e") ? S_BE    : S_OTHER;
                    S_BE:    w_next = (i_ch == "g") ? S_BEG   : S_OTHER;
                    S_BEG:   w_next = (i_ch == "i") ? S_BEGI  : S_OTHER;
                    S_BEGI:  w_next = (i_ch == "n") ? S_BEGIN : S_OTHER;
                    S_E:     w_next = (i_ch == "n") ? S_EN    : S_OTHER;
                    S_EN:    w_next = (i_ch == "d") ? S_END   : S_OTHER;
                    default: w_next = S_OTHER;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_at_begin   = (r_state == S_BEGIN);
    assign o_at_end     = (r_state == S_END);
    assign o_next_begin = (w_next == S_BEGIN);
    assign o_next_end   = (w_next == S_END);

endmodule
`default_nettype wire

// File: rtl/block_nest_checker.sv
`default_nettype none
// ============================================================================
// Module      : block_nest_checker
// Description : Tracks BEGIN/END nesting depth in an ASCII stream with sticky
//               underflow/overflow flags and optional provisional display.
// Revision    : 1.0 - initial release
// ============================================================================
module block_nest_checker
    import block_chk_pkg::*;
#(
    parameter int DEPTH_W      = 8,
    parameter int MAX_DEPTH    = 255,
    parameter int PUNCT_DELIM  = 0,
    parameter int EARLY_COMMIT = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    block_nest_checker_if.slave bus
);

    localparam logic [DEPTH_W-1:0] c_max_depth = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] c_one       = DEPTH_W'(1);

    logic [7:0]         w_ch;
    logic               w_delim;
    logic               w_at_begin, w_at_end;
    logic               w_commit_begin, w_commit_end;
    logic               w_next_begin, w_next_end;

    logic [DEPTH_W-1:0] r_cdepth, w_cdepth_nxt;
    logic               r_err_uf, w_err_uf_nxt;
    logic               r_err_of, w_err_of_nxt;
    logic [DEPTH_W-1:0] r_depth, w_disp;
    logic               r_balanced, w_balanced;
    logic               w_prov_uf;
    logic               w_unused_state;

    assign w_ch    = fold_lower(bus.in);
    assign w_delim = is_delim(bus.in, PUNCT_DELIM != 0);

    kw_matcher u_matcher (
        .clk            (clk),
        .rst            (reset),
        .i_in_valid     (bus.in_valid),
        .i_ch           (w_ch),
        .i_delim        (w_delim),
        .o_at_begin     (w_at_begin),
        .o_at_end       (w_at_end),
        .o_commit_begin (w_commit_begin),
        .o_commit_end   (w_commit_end),
        .o_next_begin   (w_next_begin),
        .o_next_end     (w_next_end)
    );

    assign w_unused_state = w_at_begin ^ w_at_end;

    always_comb begin
        w_cdepth_nxt = r_cdepth;
        w_err_uf_nxt = r_err_uf;
        w_err_of_nxt = r_err_of;
        if (w_commit_begin) begin
            if (r_cdepth < c_max_depth) w_cdepth_nxt = r_cdepth + c_one;
            else                        w_err_of_nxt = 1'b1;
        end
        if (w_commit_end) begin
            if (r_cdepth != '0) w_cdepth_nxt = r_cdepth - c_one;
            else                w_err_uf_nxt = 1'b1;
        end

        // A keyword awaiting its delimiter is shown as already counted
        w_disp    = w_cdepth_nxt;
        w_prov_uf = 1'b0;
        if (EARLY_COMMIT != 0) begin
            if (w_next_begin) begin
                w_disp = (w_cdepth_nxt < c_max_depth) ? (w_cdepth_nxt + c_one) : c_max_depth;
            end else if (w_next_end) begin
                if (w_cdepth_nxt != '0) w_disp    = w_cdepth_nxt - c_one;
                else                    w_prov_uf = 1'b1;
            end
        end
        w_balanced = (w_disp == '0) && !w_err_uf_nxt && !w_err_of_nxt && !w_prov_uf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cdepth   <= '0;
            r_err_uf   <= 1'b0;
            r_err_of   <= 1'b0;
            r_depth    <= '0;
            r_balanced <= 1'b1;
        end else if (bus.in_valid) begin
            r_cdepth   <= w_cdepth_nxt;
            r_err_uf   <= w_err_uf_nxt;
            r_err_of   <= w_err_of_nxt;
            r_depth    <= w_disp;
            r_balanced <= w_balanced;
        end
    end

    assign bus.depth         = r_depth;
    assign bus.balanced      = r_balanced;
    assign bus.err_underflow = r_err_uf;
    assign bus.err_overflow  = r_err_of;

endmodule
`default_nettype wire

// File: tb/tb_block_nest_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_nest_checker
// Description : Scoreboard bench driving one stream into three configurations
//               of the checker and comparing against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_nest_checker;

    typedef struct packed {
        logic [7:0] dep;
        logic       bal;
        logic       uf;
        logic       of;
    } obs_t;

    localparam int MX[3] = '{255, 3, 255};
    localparam bit EA[3] = '{1'b1, 1'b1, 1'b0};
    localparam bit PD[3] = '{1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vld = 1'b0;
    logic [7:0] ch = 8'h00;
    always #5 clk = ~clk;

    block_nest_checker_if #(.DEPTH_W(8)) if0 ();
    block_nest_checker_if #(.DEPTH_W(2)) if1 ();
    block_nest_checker_if #(.DEPTH_W(8)) if2 ();

    assign if0.in_valid = vld;  assign if0.in = ch;
    assign if1.in_valid = vld;  assign if1.in = ch;
    assign if2.in_valid = vld;  assign if2.in = ch;

    block_nest_checker #(.DEPTH_W(8), .MAX_DEPTH(255), .PUNCT_DELIM(0), .EARLY_COMMIT(1))
        dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    block_nest_checker #(.DEPTH_W(2), .MAX_DEPTH(3), .PUNCT_DELIM(0), .EARLY_COMMIT(1))
        dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    block_nest_checker #(.DEPTH_W(8), .MAX_DEPTH(255), .PUNCT_DELIM(1), .EARLY_COMMIT(0))
        dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    obs_t q0[$], q1[$], q2[$];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model: keeps the current word text and a committed depth per config
    int         m_cd[3];
    bit         m_uf[3], m_of[3];
    logic [7:0] m_w[3][8];
    int         m_wl[3];

    function automatic bit word_is(int m, string k);
        if (m_wl[m] != k.len()) return 1'b0;
        for (int i = 0; i < k.len(); i++)
            if (m_w[m][i] != k[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_delim(int m, logic [7:0] c);
        if (c == 8'h20) return 1'b1;
        if (PD[m] && (c == 8'h09 || c == 8'h0A || c == 8'h0D || c == 8'h2C || c == 8'h3B))
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(int m, bit r, bit v, logic [7:0] c);
        logic [7:0] lc;
        if (r) begin
            m_cd[m] = 0; m_uf[m] = 0; m_of[m] = 0; m_wl[m] = 0;
        end else if (v) begin
            lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
            if (model_delim(m, c)) begin
                if (word_is(m, "begin")) begin
                    if (m_cd[m] < MX[m]) m_cd[m]++; else m_of[m] = 1;
                end else if (word_is(m, "end")) begin
                    if (m_cd[m] > 0) m_cd[m]--; else m_uf[m] = 1;
                end
                m_wl[m] = 0;
            end else if (m_wl[m] < 7) begin
                m_w[m][m_wl[m]] = lc;
                m_wl[m]++;
            end
        end
    endtask

    function automatic obs_t model_obs(int m);
        obs_t o;
        int d;
        bit prov;
        d = m_cd[m];
        prov = 0;
        if (EA[m] && word_is(m, "begin")) d = (m_cd[m] < MX[m]) ? m_cd[m] + 1 : MX[m];
        else if (EA[m] && word_is(m, "end")) begin
            if (m_cd[m] > 0) d = m_cd[m] - 1; else prov = 1;
        end
        o.dep = 8'(d);
        o.uf  = m_uf[m];
        o.of  = m_of[m];
        o.bal = (d == 0) && !m_uf[m] && !m_of[m] && !prov;
        return o;
    endfunction

    task automatic drive(bit r, bit v, logic [7:0] c);
        @(negedge clk);
        reset = r; vld = v; ch = c;
        for (int m = 0; m < 3; m++) model_step(m, r, v, c);
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
        q2.push_back(model_obs(2));
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) drive(1'b0, 1'b1, s[i]);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic check(string name, obs_t act, obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got dep=%0d bal=%0b uf=%0b of=%0b, need dep=%0d bal=%0b uf=%0b of=%0b",
                     name, $time, act.dep, act.bal, act.uf, act.of, exp.dep, exp.bal, exp.uf, exp.of);
        end
    endtask

    // Monitor: one registered result per clock, compared after the edge
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
                e = q0.pop_front();
                a.dep = if0.depth; a.bal = if0.balanced; a.uf = if0.err_underflow; a.of = if0.err_overflow;
                check("dut0_default", a, e);
                e = q1.pop_front();
                a.dep = {6'd0, if1.depth}; a.bal = if1.balanced; a.uf = if1.err_underflow; a.of = if1.err_overflow;
                check("dut1_max3", a, e);
                e = q2.pop_front();
                a.dep = if2.depth; a.bal = if2.balanced; a.uf = if2.err_underflow; a.of = if2.err_overflow;
                check("dut2_late_punct", a, e);
            end
        end
    end

    string toks[10] = '{"begin", "end", "BEGIN", "End", "beginn", "endd", "bEgIn", "x", "be", "eNd"};
    logic [7:0] dels[6] = '{8'h20, 8'h2C, 8'h3B, 8'h09, 8'h0A, 8'h0D};

    initial begin
        int wait_cnt;
        logic [7:0] c;
        do_reset();
        do_reset();
        send_str(" begin end ");
        send_str("BEgIn beginn ");
        do_reset();
        send_str("End ");
        send_str("begin end ");
        do_reset();
        repeat (4) send_str("begin ");
        do_reset();
        send_str("begin,en");
        idle(5);
        send_str("d;");
        do_reset();
        send_str("beg");
        drive(1'b1, 1'b1, "i");
        send_str("n end ");
        do_reset();

        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            if ($urandom_range(0, 9) == 0) begin
                c = 8'($urandom_range(33, 126));
                drive(1'b0, 1'b1, c);
            end else begin
                string s;
                s = toks[$urandom_range(0, 9)];
                for (int i = 0; i < s.len(); i++) begin
                    if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
                    drive(1'b0, 1'b1, s[i]);
                end
            end
            repeat ($urandom_range(1, 2)) drive(1'b0, 1'b1, dels[$urandom_range(0, 5)]);
        end
        idle(2);

        wait_cnt = 0;
        while (q0.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        n_chk++;
        if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, need 0", q0.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
